// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;
  typedef enum logic [1:0] {IDLE, OP, DONE} state_t;
  localparam int         N_DIGITS  = 4;
  localparam int         BCD_MAX   = 9999;
  localparam logic [3:0] OVF_DIGIT = 4'hF;
endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a nibble of 5 or more gets +3 before the shift.
module bcd_digit_adj (
  input  logic [3:0] i_nib,
  output logic [3:0] o_nib
);
  assign o_nib = (i_nib >= 4'd5) ? i_nib + 4'd3 : i_nib;
endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 converter, one input bit per clock, feeding the
// 4-digit seven-segment driver. Values above 9999 show as FFFF with overflow set.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             ready,
  output logic             done_tick,
  output logic             overflow,
  output logic [3:0]       bcd3,
  output logic [3:0]       bcd2,
  output logic [3:0]       bcd1,
  output logic [3:0]       bcd0
);
  localparam int CNT_W  = $clog2(BIN_W + 1);
  localparam int WORK_W = 4 * N_DIGITS;

  state_t            r_state;
  logic [BIN_W-1:0]  r_shift;
  logic [WORK_W-1:0] r_work;
  logic [WORK_W-1:0] r_bcd;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_ovf_pend;
  logic              r_ready;
  logic              r_done;
  logic              r_ovf;

  logic [WORK_W-1:0] w_adj;
  logic [WORK_W-1:0] w_work_nxt;
  logic              w_big;

  for (genvar g = 0; g < N_DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .i_nib(r_work[4*g +: 4]),
      .o_nib(w_adj[4*g +: 4])
    );
  end

  // Carry out of the thousands digit is dropped; only possible when overflowing.
  assign w_work_nxt = {w_adj[WORK_W-2:0], r_shift[BIN_W-1]};
  assign w_big      = {{(32-BIN_W){1'b0}}, bin} > 32'(BCD_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_work     <= '0;
      r_bcd      <= '0;
      r_cnt      <= '0;
      r_ovf_pend <= 1'b0;
      r_ready    <= 1'b1;
      r_done     <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          r_shift    <= bin;
          r_work     <= '0;
          r_cnt      <= CNT_W'(BIN_W);
          r_ovf_pend <= w_big;
          r_ready    <= 1'b0;
          r_state    <= OP;
        end
        OP: begin
          r_work  <= w_work_nxt;
          r_shift <= {r_shift[BIN_W-2:0], 1'b0};
          r_cnt   <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_state <= DONE;
            r_done  <= 1'b1;
            r_bcd   <= r_ovf_pend ? {N_DIGITS{OVF_DIGIT}} : w_work_nxt;
            r_ovf   <= r_ovf_pend;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign ready     = r_ready;
  assign done_tick = r_done;
  assign overflow  = r_ovf;
  assign bcd3      = r_bcd[15:12];
  assign bcd2      = r_bcd[11:8];
  assign bcd1      = r_bcd[7:4];
  assign bcd0      = r_bcd[3:0];
endmodule
